core_fetch: RTL
===============

// Module: core_fetch
// PURPOSE
//  Instruction fetch front end: producer of the insn/insn_pc/stall stream that core_decode consumes.
//  Issues sequential halfword reads to instruction memory and buffers them in a DEPTH-entry prefetch FIFO.
//  Presents one instruction per cycle to decode, or a NOP bubble when the FIFO is empty.
//  Redirects on a taken branch from execute, discarding every fetched-but-undelivered instruction.
// PARAMETERS
//  PTR_W     15        halfword pointer width (hptr); PC counts halfwords
//  DEPTH     4         prefetch FIFO entries (power of 2, >=2)
//  RESET_PC  0         PTR_W-bit PC after reset
//  NOP_INSN  16'h0000  encoding driven on insn for bubbles
// PORTS
//  clk          in   1      clock; all state updates on posedge
//  rst          in   1      synchronous reset, active-high
//  fetch        out  1      memory read request
//  fetch_addr   out  PTR_W  halfword address of the request
//  ready        in   1      memory accepts the request; fetch_data valid this same cycle
//  fetch_data   in   16     instruction halfword
//  redirect     in   1      taken branch: restart fetch at redirect_pc
//  redirect_pc  in   PTR_W  branch target
//  stall        in   1      decode not accepting; hold insn/insn_pc (same signal as decode's stall)
//  insn         out  16     instruction to decode (registered)
//  insn_pc      out  PTR_W  address of insn (registered)
//  bubble       out  1      1 when insn is a fill NOP rather than a fetched instruction
// BEHAVIOUR
//  Reset (rst=1 at posedge): pc=RESET_PC, FIFO count=0, insn=NOP_INSN, insn_pc=RESET_PC, bubble=1.
//   Mid-operation reset discards any pending request; fetch=0 in the cycle rst is high.
//  Priority per cycle: rst > redirect > normal operation.
//  Request: fetch = !rst && !redirect && (count < DEPTH); fetch_addr = pc.
//   Handshake completes when fetch && ready; then pc <= pc+1 (mod 2^PTR_W; wraps to 0).
//   While fetch=1 and ready=0, fetch_addr stays stable; only redirect or rst may withdraw fetch.
//   Count never increases while a request is outstanding, so fetch cannot drop without redirect/rst.
//  Delivery (no rst, no redirect, stall=0), at posedge:
//   FIFO non-empty: insn/insn_pc <= head entry, pop, bubble<=0; a simultaneous accepted fetch pushes.
//   FIFO empty and fetch&&ready: bypass, insn<=fetch_data, insn_pc<=fetch_addr, bubble<=0; no push.
//   FIFO empty, no accept: insn<=NOP_INSN, insn_pc unchanged, bubble<=1.
//   Latency: accepted fetch -> insn on the next posedge if FIFO empty; in program order always.
//  Stall=1: insn/insn_pc/bubble hold; accepted fetches still push until count==DEPTH.
//   Full (count==DEPTH): fetch=0 that cycle, even if a pop happens in it; fetch resumes next cycle.
//  Redirect=1 (overrides stall): FIFO cleared (count<=0), pc<=redirect_pc, insn<=NOP_INSN,
//   insn_pc<=redirect_pc, bubble<=1; fetch=0 that cycle, ready/fetch_data ignored.
//   The first target fetch is issued in the following cycle.
//  FIFO: circular buffer, rd/wr pointers log2(DEPTH) bits wrap naturally; count 0..DEPTH.
//   Push and pop in one cycle leave count unchanged.
//  No X on outputs after reset; FIFO storage contents are don't-care when not valid.
// TESTING
//  1 Reset, ready=1 always, stall=0 -> fetch_addr 0,1,2,...; insn_pc follows one cycle later;
//    bubble=1 only in the first cycle after reset.
//  2 ready held low 3 cycles at fetch_addr=5 -> fetch_addr stays 5; insn NOP with bubble=1;
//    after ready, insn_pc=5 on the next cycle.
//  3 stall=1 for 6 cycles with ready=1 -> exactly 4 pushes (DEPTH=4), fetch=0 once full,
//    insn held; release -> insn_pc runs consecutively with no gap and no duplicate.
//  4 FIFO holds pcs 10..13 and redirect with redirect_pc=0x40 -> next insn is NOP, bubble=1;
//    pcs 10..13 are never delivered; the next fetch_addr is 0x40.
//  5 redirect and stall together, with ready=1 in the same cycle -> the redirect wins;
//    fetch_data is discarded; insn_pc=redirect_pc, bubble=1.
//  6 RESET_PC=0x7FFE, ready=1 -> fetch_addr 0x7FFE,0x7FFF,0x0000 (wrap);
//    rst asserted mid-stall -> every output returns to its reset value next cycle.

Source files
------------

// File: rtl/core_fetch_if.sv
// Instruction-memory read port: fetch/fetch_addr request, ready/fetch_data same-cycle response.
// master = fetch unit, slave = instruction memory.
interface core_fetch_if #(
  parameter int PTR_W = 15
);
  logic             fetch;
  logic [PTR_W-1:0] fetch_addr;
  logic             ready;
  logic [15:0]      fetch_data;

  modport master (output fetch, output fetch_addr, input ready, input fetch_data);
  modport slave  (input fetch, input fetch_addr, output ready, output fetch_data);
endinterface

// File: rtl/core_fetch.sv
// Fetch front end: sequential halfword reads into a DEPTH-entry prefetch FIFO, one insn per cycle to decode.
// Empty-FIFO accept bypasses to insn next edge; stall holds insn and fills the FIFO; full or redirect drops fetch.
module core_fetch #(
  parameter int               PTR_W    = 15,
  parameter int               DEPTH    = 4,
  parameter logic [PTR_W-1:0] RESET_PC = '0,
  parameter logic [15:0]      NOP_INSN = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  core_fetch_if.master     mem,
  input  logic             redirect,
  input  logic [PTR_W-1:0] redirect_pc,
  input  logic             stall,
  output logic [15:0]      insn,
  output logic [PTR_W-1:0] insn_pc,
  output logic             bubble
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [15:0]      dat;
    logic [PTR_W-1:0] pc;
  } entry_t;

  entry_t           fifo_q [DEPTH];
  logic [PTR_W-1:0] pc;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             empty;
  logic             accept;
  logic             push;
  logic             pop;

  assign empty          = (count == '0);
  assign mem.fetch      = !rst && !redirect && (count < CW'(DEPTH));
  assign mem.fetch_addr = pc;
  assign accept         = mem.fetch && mem.ready;
  assign pop            = !stall && !empty;
  // An accept only skips the FIFO when it can go straight out to decode.
  assign push           = accept && (stall || !empty);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= entry_t'{dat: mem.fetch_data, pc: pc};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      insn    <= NOP_INSN;
      insn_pc <= RESET_PC;
      bubble  <= 1'b1;
    end else if (redirect) begin
      pc      <= redirect_pc;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      insn    <= NOP_INSN;
      insn_pc <= redirect_pc;
      bubble  <= 1'b1;
    end else begin
      if (accept) begin
        pc <= pc + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
      if (!stall) begin
        if (!empty) begin
          insn    <= fifo_q[rd_ptr].dat;
          insn_pc <= fifo_q[rd_ptr].pc;
          bubble  <= 1'b0;
        end else if (accept) begin
          insn    <= mem.fetch_data;
          insn_pc <= pc;
          bubble  <= 1'b0;
        end else begin
          insn   <= NOP_INSN;
          bubble <= 1'b1;
        end
      end
    end
  end
endmodule
